rs_dec_ctrl: RTL

Sequencer for the RS(255,247) decoder (T=4). It accepts one syndrome-ready event per received codeword and runs the datapath stages in order: key-equation solver (KES), Chien search, Forney evaluator, then correction write-back. It enforces uncorrectable-frame detection and per-stage timeouts, and reports a per-frame result. It sits between the syndrome calculator and the KES/chien/forney/correction blocks, and holds a one-deep pending slot so the syndrome stage can run one frame ahead.

---
 rtl/rs_pkg.sv | 29 ++
 rtl/rs_dec_ctrl_if.sv | 47 ++++
 rtl/rs_watchdog.sv | 26 ++
 rtl/rs_dec_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(255,247) decoder control path.
package rs_pkg;

  localparam int RS_T  = 4;
  localparam int RS_N  = 255;
  localparam int ERR_W = 3;
  localparam int WD_W  = 9;

  typedef enum logic [2:0] {
    IDLE,
    KES_W,
    CHIEN_W,
    FORNEY_W,
    CORR_W
  } state_t;

  // Registered single-cycle outputs of the sequencer.
  typedef struct packed {
    logic             kes_start;
    logic             chien_start;
    logic             forney_start;
    logic             corr_start;
    logic             result_valid;
    logic             result_fail;
    logic             result_timeout;
    logic [ERR_W-1:0] result_err_cnt;
  } ctrl_out_t;

endpackage

// File: rtl/rs_dec_ctrl_if.sv
// Signal bundle between the decoder sequencer and the syndrome/KES/Chien/Forney/correction blocks.
interface rs_dec_ctrl_if;
  import rs_pkg::*;

  // syn_valid is a one-cycle event, not a held request: a frame offered while
  // syn_ready is low and the sequencer is busy is dropped and flags overflow.
  // Every *_done is a one-cycle pulse qualifying its data; *_start are pulses.
  logic             syn_valid;
  logic             syn_zero;
  logic             syn_ready;
  logic             kes_start;
  logic             kes_done;
  logic [ERR_W-1:0] kes_err_num;
  logic             chien_start;
  logic [ERR_W-1:0] chien_err_num;
  logic             chien_done;
  logic [ERR_W-1:0] chien_root_cnt;
  logic             forney_start;
  logic             forney_done;
  logic             corr_start;
  logic             corr_done;
  logic             result_valid;
  logic             result_fail;
  logic             result_timeout;
  logic [ERR_W-1:0] result_err_cnt;
  logic             overflow;
  logic [15:0]      fail_cnt;
  logic             busy;
  state_t           state;

  modport master (
    input  syn_valid, syn_zero, kes_done, kes_err_num, chien_done, chien_root_cnt,
           forney_done, corr_done,
    output syn_ready, kes_start, chien_start, chien_err_num, forney_start, corr_start,
           result_valid, result_fail, result_timeout, result_err_cnt, overflow,
           fail_cnt, busy, state
  );

  modport slave (
    output syn_valid, syn_zero, kes_done, kes_err_num, chien_done, chien_root_cnt,
           forney_done, corr_done,
    input  syn_ready, kes_start, chien_start, chien_err_num, forney_start, corr_start,
           result_valid, result_fail, result_timeout, result_err_cnt, overflow,
           fail_cnt, busy, state
  );

endinterface

// File: rtl/rs_watchdog.sv
// Per-state watchdog: cleared on state entry, counts cycles while enabled.
module rs_watchdog
  import rs_pkg::*;
#(
  parameter int TIMEOUT = 511
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  // Fires on the cycle whose count would reach TIMEOUT.
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign timeout = en && (cnt_q == LAST);

endmodule

// File: rtl/rs_dec_ctrl.sv
// RS(255,247) decoder sequencer: KES -> Chien -> Forney -> correction, with a one-deep pending slot.
module rs_dec_ctrl
  import rs_pkg::*;
#(
  parameter int T       = RS_T,
  parameter int TIMEOUT = 511
) (
  input logic           clk,
  input logic           rst,
  rs_dec_ctrl_if.master bus
);

  state_t           state_q, state_d;
  ctrl_out_t        out_q, out_d;
  logic             slot_full_q, slot_full_d;
  logic             slot_zero_q, slot_zero_d;
  logic [ERR_W-1:0] err_num_q, err_num_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      fail_cnt_q, fail_cnt_d;
  logic             take, take_zero, fail, timed_out;
  logic             wd_timeout;

  rs_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .en      (state_q != IDLE),
    .timeout (wd_timeout)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = '0;
    slot_full_d = slot_full_q;
    slot_zero_d = slot_zero_q;
    err_num_d   = err_num_q;
    overflow_d  = overflow_q;
    fail_cnt_d  = fail_cnt_q;
    take        = 1'b0;
    take_zero   = 1'b0;
    fail        = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      IDLE: begin
        // The held frame goes first; a coincident arrival refills the slot.
        if (slot_full_q) begin
          take        = 1'b1;
          take_zero   = slot_zero_q;
          slot_full_d = bus.syn_valid;
          slot_zero_d = bus.syn_zero;
        end else if (bus.syn_valid) begin
          take      = 1'b1;
          take_zero = bus.syn_zero;
        end
        if (take && take_zero) begin
          out_d.result_valid = 1'b1;
        end else if (take) begin
          out_d.kes_start = 1'b1;
          state_d         = KES_W;
        end
      end
      KES_W: begin
        if (bus.kes_done) begin
          if (bus.kes_err_num == '0 || int'(bus.kes_err_num) > T) begin
            fail = 1'b1;
          end else begin
            err_num_d         = bus.kes_err_num;
            out_d.chien_start = 1'b1;
            state_d           = CHIEN_W;
          end
        end else if (wd_timeout) begin
          timed_out = 1'b1;
        end
      end
      CHIEN_W: begin
        if (bus.chien_done) begin
          if (bus.chien_root_cnt != err_num_q) begin
            fail = 1'b1;
          end else begin
            out_d.forney_start = 1'b1;
            state_d            = FORNEY_W;
          end
        end else if (wd_timeout) begin
          timed_out = 1'b1;
        end
      end
      FORNEY_W: begin
        if (bus.forney_done) begin
          out_d.corr_start = 1'b1;
          state_d          = CORR_W;
        end else if (wd_timeout) begin
          timed_out = 1'b1;
        end
      end
      CORR_W: begin
        if (bus.corr_done) begin
          out_d.result_valid   = 1'b1;
          out_d.result_err_cnt = err_num_q;
          state_d              = IDLE;
        end else if (wd_timeout) begin
          timed_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail || timed_out) begin
      out_d.result_valid   = 1'b1;
      out_d.result_fail    = 1'b1;
      out_d.result_timeout = timed_out;
      state_d              = IDLE;
    end

    if (out_d.result_fail && fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;

    if (state_q != IDLE && bus.syn_valid) begin
      if (!slot_full_q) begin
        slot_full_d = 1'b1;
        slot_zero_d = bus.syn_zero;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      slot_full_q <= 1'b0;
      slot_zero_q <= 1'b0;
      err_num_q   <= '0;
      overflow_q  <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      slot_full_q <= slot_full_d;
      slot_zero_q <= slot_zero_d;
      err_num_q   <= err_num_d;
      overflow_q  <= overflow_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign bus.syn_ready      = !slot_full_q;
  assign bus.kes_start      = out_q.kes_start;
  assign bus.chien_start    = out_q.chien_start;
  assign bus.chien_err_num  = err_num_q;
  assign bus.forney_start   = out_q.forney_start;
  assign bus.corr_start     = out_q.corr_start;
  assign bus.result_valid   = out_q.result_valid;
  assign bus.result_fail    = out_q.result_fail;
  assign bus.result_timeout = out_q.result_timeout;
  assign bus.result_err_cnt = out_q.result_err_cnt;
  assign bus.overflow       = overflow_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.state          = state_q;

endmodule
